// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction-fetch stage. Owns the fetch PC, issues requests on a
// valid/ready channel, tags in-flight requests with their address, buffers returned words
// in a 2-entry queue and drives the IF/ID registers. Redirects from decode discard any
// responses still in flight for the old path.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic [1:0]      pc_sel,
    input  logic            br_true,
    input  logic [XLEN-1:0] br_decode,
    input  logic [XLEN-1:0] jal_decode,
    input  logic [XLEN-1:0] jalr_decode,
    input  logic            stall_id,
    input  logic            flush_if,
    output logic [XLEN-1:0] pc_decode,
    output logic [XLEN-1:0] instr_decode,
    output logic            valid_decode
);

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_BR    = 2'd1;
    localparam logic [1:0] PC_JAL   = 2'd2;
    localparam logic [1:0] PC_JALR  = 2'd3;

    logic [XLEN-1:0] r_pc_fetch;
    logic [1:0]      r_outstanding;
    logic [1:0]      r_drop;
    logic [XLEN-1:0] r_tag [2];
    logic            r_tag_rd;
    logic            r_tag_wr;
    logic [XLEN-1:0] r_fifo_pc [2];
    logic [XLEN-1:0] r_fifo_instr [2];
    logic            r_fifo_rd;
    logic            r_fifo_wr;
    logic [1:0]      r_fifo_cnt;
    logic [XLEN-1:0] r_pc_decode;
    logic [XLEN-1:0] r_instr_decode;
    logic            r_valid_decode;

    logic            w_redirect_req;
    logic [XLEN-1:0] w_target_raw;
    logic            w_redirect;
    logic [XLEN-1:0] w_target;
    logic            w_pop;
    logic [2:0]      w_credit;
    logic            w_req_valid;
    logic            w_accept;
    logic            w_resp;
    logic            w_push;
    logic [1:0]      w_outstanding_nxt;
    logic [1:0]      w_drop_nxt;

    // Decode-side redirect request and the raw target it selects
    always_comb begin
        w_redirect_req = 1'b0;
        w_target_raw   = jalr_decode;
        unique case (pc_sel)
            PC_PLUS4: begin
                w_redirect_req = 1'b0;
                w_target_raw   = jalr_decode;
            end
            PC_BR: begin
                w_redirect_req = br_true;
                w_target_raw   = br_decode;
            end
            PC_JAL: begin
                w_redirect_req = 1'b1;
                w_target_raw   = jal_decode;
            end
            PC_JALR: begin
                w_redirect_req = 1'b1;
                w_target_raw   = jalr_decode;
            end
            default: ;
        endcase
    end

    assign w_redirect = w_redirect_req && !stall_id;
    assign w_target   = {w_target_raw[XLEN-1:2], 2'b00};

    // Credit counts the same-cycle pop so a zero-wait memory sustains one word per cycle
    assign w_pop       = (r_fifo_cnt != 2'd0) && !stall_id && !flush_if;
    assign w_credit    = 3'(r_outstanding) + 3'(r_fifo_cnt) - 3'(w_pop);
    // Held low while in reset so no request leaks out before the first post-reset cycle
    assign w_req_valid = rst && !w_redirect && (w_credit < 3'd2);
    assign w_accept    = w_req_valid && imem_req_ready;

    // Stray responses with nothing in flight are ignored
    assign w_resp = imem_resp_valid && (r_outstanding != 2'd0);
    assign w_push = w_resp && (r_drop == 2'd0) && !w_redirect;

    assign w_outstanding_nxt = r_outstanding + 2'(w_accept) - 2'(w_resp);

    // Drop count: everything still in flight after a redirect belongs to the old path
    always_comb begin
        w_drop_nxt = r_drop;
        if (w_redirect) begin
            w_drop_nxt = w_outstanding_nxt;
        end else if (w_resp && (r_drop != 2'd0)) begin
            w_drop_nxt = r_drop - 2'd1;
        end
    end

    // Fetch PC: advance on accept, jump to the aligned target on redirect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc_fetch <= RESET_PC;
        end else if (w_redirect) begin
            r_pc_fetch <= w_target;
        end else if (w_accept) begin
            r_pc_fetch <= r_pc_fetch + XLEN'(4);
        end
    end

    // In-flight and drop counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_outstanding <= 2'd0;
            r_drop        <= 2'd0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            r_drop        <= w_drop_nxt;
        end
    end

    // Tag queue: address of each outstanding request, popped by every counted response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag[0] <= '0;
            r_tag[1] <= '0;
            r_tag_wr <= 1'b0;
            r_tag_rd <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tag[r_tag_wr] <= r_pc_fetch;
                r_tag_wr        <= ~r_tag_wr;
            end
            if (w_resp) begin
                r_tag_rd <= ~r_tag_rd;
            end
        end
    end

    // Instruction queue: push kept responses, pop into IF/ID, clear on redirect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fifo_pc[0]    <= '0;
            r_fifo_pc[1]    <= '0;
            r_fifo_instr[0] <= '0;
            r_fifo_instr[1] <= '0;
            r_fifo_rd       <= 1'b0;
            r_fifo_wr       <= 1'b0;
            r_fifo_cnt      <= 2'd0;
        end else if (w_redirect) begin
            r_fifo_rd  <= 1'b0;
            r_fifo_wr  <= 1'b0;
            r_fifo_cnt <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_pc[r_fifo_wr]    <= r_tag[r_tag_rd];
                r_fifo_instr[r_fifo_wr] <= imem_resp_data;
                r_fifo_wr               <= ~r_fifo_wr;
            end
            if (w_pop) begin
                r_fifo_rd <= ~r_fifo_rd;
            end
            r_fifo_cnt <= r_fifo_cnt + 2'(w_push) - 2'(w_pop);
        end
    end

    // IF/ID registers: stall holds, redirect/flush/empty load a bubble, else pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc_decode    <= '0;
            r_instr_decode <= '0;
            r_valid_decode <= 1'b0;
        end else if (!stall_id) begin
            if (w_redirect || flush_if || (r_fifo_cnt == 2'd0)) begin
                r_pc_decode    <= '0;
                r_instr_decode <= '0;
                r_valid_decode <= 1'b0;
            end else begin
                r_pc_decode    <= r_fifo_pc[r_fifo_rd];
                r_instr_decode <= r_fifo_instr[r_fifo_rd];
                r_valid_decode <= 1'b1;
            end
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pc_fetch;
    assign pc_decode      = r_pc_decode;
    assign instr_decode   = r_instr_decode;
    assign valid_decode   = r_valid_decode;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: drives fetch_unit with directed and random decode/memory traffic and
// compares every cycle against a queue-based model of the fetch stage.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [1:0]  pc_sel;
    logic        br_true;
    logic [31:0] br_decode;
    logic [31:0] jal_decode;
    logic [31:0] jalr_decode;
    logic        stall_id;
    logic        flush_if;
    logic [31:0] pc_decode;
    logic [31:0] instr_decode;
    logic        valid_decode;

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .pc_sel          (pc_sel),
        .br_true         (br_true),
        .br_decode       (br_decode),
        .jal_decode      (jal_decode),
        .jalr_decode     (jalr_decode),
        .stall_id        (stall_id),
        .flush_if        (flush_if),
        .pc_decode       (pc_decode),
        .instr_decode    (instr_decode),
        .valid_decode    (valid_decode)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        live;
    } req_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    // Model: in-flight requests in order (dead ones belong to a squashed path) and the queue
    req_t        m_inflight[$];
    ent_t        m_fifo[$];
    logic [31:0] m_pc_fetch;
    logic [31:0] m_pc_dec;
    logic [31:0] m_instr_dec;
    logic        m_valid_dec;

    int n_vec = 0;
    int n_err = 0;

    // Decode-side stimulus for the next cycle
    logic [1:0]  s_sel;
    logic        s_br_true;
    logic [31:0] s_br;
    logic [31:0] s_jal;
    logic [31:0] s_jalr;
    logic        s_stall;
    logic        s_flush;
    bit          zero_wait;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_inflight.delete();
        m_fifo.delete();
        m_pc_fetch  = 32'h0;
        m_pc_dec    = 32'h0;
        m_instr_dec = 32'h0;
        m_valid_dec = 1'b0;
    endtask

    task automatic idle_inputs();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        pc_sel          = 2'd0;
        br_true         = 1'b0;
        br_decode       = 32'h0;
        jal_decode      = 32'h0;
        jalr_decode     = 32'h0;
        stall_id        = 1'b0;
        flush_if        = 1'b0;
    endtask

    task automatic clear_decode();
        s_sel = 2'd0; s_br_true = 1'b0; s_br = 32'h0; s_jal = 32'h0; s_jalr = 32'h0;
        s_stall = 1'b0; s_flush = 1'b0;
    endtask

    function automatic logic [31:0] pick_target();
        if ($urandom_range(3) == 0) return 32'hFFFF_FFF0 + 32'($urandom_range(15));
        return $urandom;
    endfunction

    task automatic rand_decode();
        int r;
        s_stall   = ($urandom_range(99) < 15);
        s_flush   = ($urandom_range(99) < 10);
        r         = $urandom_range(99);
        s_sel     = (r < 75) ? 2'd0 : 2'($urandom_range(3));
        s_br_true = $urandom_range(1) == 1;
        s_br      = pick_target();
        s_jal     = pick_target();
        s_jalr    = pick_target();
    endtask

    // One clock cycle: drive inputs after the edge, compare at the falling edge, step model
    task automatic run_cycle();
        bit          redirect;
        bit          pop;
        bit          exp_valid;
        bit          accept;
        int          credit;
        logic [31:0] target;
        req_t        q;
        ent_t        e;
        @(posedge clk);
        #1;
        if (zero_wait) begin
            imem_req_ready  = 1'b1;
            imem_resp_valid = m_inflight.size() > 0;
            imem_resp_data  = (m_inflight.size() > 0) ? m_inflight[0].addr : 32'h0;
        end else begin
            imem_req_ready  = $urandom_range(9) < 7;
            imem_resp_valid = (m_inflight.size() > 0) ? ($urandom_range(9) < 6)
                                                      : ($urandom_range(9) == 0);
            imem_resp_data  = $urandom;
        end
        pc_sel      = s_sel;
        br_true     = s_br_true;
        br_decode   = s_br;
        jal_decode  = s_jal;
        jalr_decode = s_jalr;
        stall_id    = s_stall;
        flush_if    = s_flush;
        @(negedge clk);

        redirect = !s_stall && (s_sel == 2'd2 || s_sel == 2'd3 || (s_sel == 2'd1 && s_br_true));
        case (s_sel)
            2'd1:    target = s_br;
            2'd2:    target = s_jal;
            default: target = s_jalr;
        endcase
        target    = target & 32'hFFFF_FFFC;
        pop       = m_fifo.size() > 0 && !s_stall && !s_flush;
        credit    = m_inflight.size() + m_fifo.size() - (pop ? 1 : 0);
        exp_valid = !redirect && credit < 2;

        chk("req_valid", imem_req_valid, exp_valid);
        chk("req_addr", imem_req_addr, m_pc_fetch);
        chk("pc_decode", pc_decode, m_pc_dec);
        chk("instr_decode", instr_decode, m_instr_dec);
        chk("valid_decode", valid_decode, m_valid_dec);

        accept = exp_valid && imem_req_ready;
        if (!s_stall) begin
            if (!redirect && !s_flush && m_fifo.size() > 0) begin
                e           = m_fifo.pop_front();
                m_pc_dec    = e.pc;
                m_instr_dec = e.instr;
                m_valid_dec = 1'b1;
            end else begin
                m_pc_dec    = 32'h0;
                m_instr_dec = 32'h0;
                m_valid_dec = 1'b0;
            end
        end
        if (imem_resp_valid && m_inflight.size() > 0) begin
            q = m_inflight.pop_front();
            if (q.live && !redirect) begin
                e.pc    = q.addr;
                e.instr = imem_resp_data;
                m_fifo.push_back(e);
            end
        end
        if (accept) begin
            q.addr = m_pc_fetch;
            q.live = 1'b1;
            m_inflight.push_back(q);
            m_pc_fetch = m_pc_fetch + 32'd4;
        end
        if (redirect) begin
            m_fifo.delete();
            foreach (m_inflight[i]) m_inflight[i].live = 1'b0;
            m_pc_fetch = target;
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_req_valid"}, imem_req_valid, 32'h0);
        chk({tag, "_req_addr"}, imem_req_addr, 32'h0);
        chk({tag, "_pc_decode"}, pc_decode, 32'h0);
        chk({tag, "_instr_decode"}, instr_decode, 32'h0);
        chk({tag, "_valid_decode"}, valid_decode, 32'h0);
    endtask

    // Asynchronous reset in the middle of a cycle; released on a falling edge with idle inputs
    task automatic mid_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_state("midrst");
        model_reset();
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        clear_decode();
        model_reset();
        zero_wait = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst = 1'b1;

        // Zero-wait memory returning address as data: 0,4,8,C from cycle 3
        for (int c = 0; c < 10; c++) begin
            run_cycle();
            if (c >= 3 && c <= 6) begin
                chk("stream_pc", pc_decode, 32'(4 * (c - 3)));
                chk("stream_instr", instr_decode, 32'(4 * (c - 3)));
                chk("stream_valid", valid_decode, 32'h1);
            end
        end

        // JALR to an unaligned target, then a one-cycle flush and a 4-cycle stall
        s_sel = 2'd3; s_jalr = 32'h0000_0203;
        run_cycle();
        chk("redirect_no_req", imem_req_valid, 32'h0);
        s_sel = 2'd0;
        run_cycle();
        chk("jalr_addr", imem_req_addr, 32'h0000_0200);
        chk("jalr_req", imem_req_valid, 32'h1);
        chk("redir_bubble1", valid_decode, 32'h0);
        run_cycle();
        chk("redir_bubble2", valid_decode, 32'h0);
        run_cycle();
        chk("redir_bubble3", valid_decode, 32'h0);
        run_cycle();
        chk("target_pc", pc_decode, 32'h0000_0200);
        chk("target_valid", valid_decode, 32'h1);
        run_cycle();
        chk("target_pc2", pc_decode, 32'h0000_0204);
        s_flush = 1'b1;
        run_cycle();
        chk("preflush_pc", pc_decode, 32'h0000_0208);
        s_flush = 1'b0;
        run_cycle();
        chk("flush_bubble", valid_decode, 32'h0);
        run_cycle();
        chk("postflush_pc", pc_decode, 32'h0000_020C);
        chk("postflush_valid", valid_decode, 32'h1);
        run_cycle();
        chk("postflush_pc2", pc_decode, 32'h0000_0210);
        s_stall = 1'b1;
        for (int c = 0; c < 4; c++) begin
            run_cycle();
            chk("stall_hold_pc", pc_decode, 32'h0000_0214);
            if (c > 0) chk("stall_no_req", imem_req_valid, 32'h0);
        end
        s_stall = 1'b0;
        run_cycle();
        chk("unstall_pc", pc_decode, 32'h0000_0214);
        run_cycle();
        chk("resume_pc", pc_decode, 32'h0000_0218);
        run_cycle();
        chk("resume_pc2", pc_decode, 32'h0000_021C);

        // Random decode and memory traffic with one asynchronous reset mid-run
        zero_wait = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                mid_reset();
            end
            rand_decode();
            run_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
